// File: rtl/gshare_index_unit.sv
// gshare_index_unit: gshare index formation, in-flight prediction queue, GHR repair and attenuation scheduling
module gshare_index_unit #(
    parameter int COUNTERPW = 6,
    parameter int PCWIDE    = 32,
    parameter int QPW       = 3,
    parameter int ATTPERIOD = 1024
) (
    input  logic                 Clk,
    input  logic                 Rest,
    input  logic                 FetchValid,
    input  logic [PCWIDE-1:0]    FetchPc,
    output logic                 FetchReady,
    output logic [COUNTERPW-1:0] ReadAddr,
    output logic                 ReadAble,
    input  logic [1:0]           DoutCounter,
    output logic                 PredValid,
    output logic                 PredTaken,
    output logic [QPW-1:0]       PredTag,
    input  logic                 ResolveValid,
    input  logic                 ResolveTaken,
    output logic [COUNTERPW-1:0] UpAddr,
    output logic                 UpdateAble,
    output logic                 RightOrFault,
    output logic                 Attenuation,
    output logic                 Mispredict
);
    localparam int QDEPTH = 1 << QPW;
    localparam int AW = $clog2(ATTPERIOD);
    localparam logic [AW-1:0] ATT_LAST = AW'(ATTPERIOD - 1);
    localparam logic [QPW+1:0] Q_LIMIT = (QPW+2)'(QDEPTH);

    logic [COUNTERPW-1:0] ghr, ghr_eff, lk_idx, lk_ghr;
    logic [COUNTERPW-1:0] q_idx [QDEPTH];
    logic [COUNTERPW-1:0] q_ghr [QDEPTH];
    logic                 q_pred [QDEPTH];
    logic [QPW-1:0]       head, tail;
    logic [QPW:0]         count;
    logic                 inflight, pending;
    logic [AW-1:0]        res_cnt;
    logic                 resolve, mispredict, pred_valid, pred_taken;
    logic                 unused_bits;

    assign unused_bits = ^{FetchPc[PCWIDE-1:COUNTERPW+2], FetchPc[1:0], DoutCounter[0]};

    // resolve/mispredict decode, prediction with squash, bypassed index and handshakes
    always_comb begin
        resolve      = Rest & ResolveValid & (count != '0);
        mispredict   = resolve & (ResolveTaken != q_pred[head]);
        pred_valid   = inflight & ~mispredict;
        pred_taken   = pred_valid & DoutCounter[1];
        ghr_eff      = pred_valid ? {ghr[COUNTERPW-2:0], pred_taken} : ghr;
        ReadAddr     = FetchPc[COUNTERPW+1:2] ^ ghr_eff;
        FetchReady   = (((QPW+2)'(count) + (QPW+2)'(inflight)) < Q_LIMIT) & ~mispredict;
        ReadAble     = Rest & FetchValid & FetchReady;
        PredValid    = pred_valid;
        PredTaken    = pred_taken;
        PredTag      = pred_valid ? tail : '0;
        UpdateAble   = resolve;
        UpAddr       = resolve ? q_idx[head] : '0;
        RightOrFault = resolve & ResolveTaken;
        Mispredict   = mispredict;
        Attenuation  = pending & ~resolve;
    end

    // control state: GHR, queue pointers, lookup tracking and attenuation scheduling
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            ghr      <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            lk_idx   <= '0;
            lk_ghr   <= '0;
            res_cnt  <= '0;
            pending  <= 1'b0;
        end else begin
            inflight <= ReadAble;
            lk_idx   <= ReadAddr;
            lk_ghr   <= ghr_eff;
            if (mispredict) begin
                ghr   <= {q_ghr[head][COUNTERPW-2:0], ResolveTaken};
                head  <= tail;
                count <= '0;
            end else begin
                if (pred_valid) begin
                    ghr  <= {lk_ghr[COUNTERPW-2:0], pred_taken};
                    tail <= tail + QPW'(1);
                end
                if (resolve)
                    head <= head + QPW'(1);
                count <= count + (QPW+1)'(pred_valid) - (QPW+1)'(resolve);
            end
            if (resolve)
                res_cnt <= (res_cnt == ATT_LAST) ? '0 : res_cnt + AW'(1);
            pending <= (resolve && res_cnt == ATT_LAST) | (pending & resolve);
        end
    end

    // queue payload written at the tail with the lookup's index and history
    always_ff @(posedge Clk) begin
        if (pred_valid) begin
            q_idx[tail]  <= lk_idx;
            q_ghr[tail]  <= lk_ghr;
            q_pred[tail] <= pred_taken;
        end
    end
endmodule

// File: doc/gshare_index_unit.md
# gshare_index_unit

Front-end companion to the 2-bit branch counter table: forms the gshare index from fetch PC and the speculative global history register (GHR), drives the table's read and update ports, and turns the returned counter into a taken/not-taken prediction. Keeps an in-order queue of in-flight predictions so that each branch trains the table with the index it was predicted from. On a misprediction it repairs the GHR. It also schedules periodic counter attenuation.

## Interface
- COUNTERPW, 6, index width; table depth 2^COUNTERPW; GHR width
- PCWIDE, 32, fetch PC width
- QPW, 3, queue pointer width; queue depth QDEPTH = 2^QPW
- ATTPERIOD, 1024, resolved branches between attenuation pulses (≥ 2)

Ports:
- Clk  in  1  clock, all state on rising edge
- Rest  in  1  asynchronous active-low reset
- FetchValid  in  1  lookup request
- FetchPc  in  PCWIDE  branch PC
- FetchReady  out  1  lookup accepted when FetchValid & FetchReady
- ReadAddr  out  COUNTERPW  table read index
- ReadAble  out  1  table read enable
- DoutCounter  in  2  table counter, valid the cycle after ReadAble
- PredValid  out  1  prediction valid
- PredTaken  out  1  predicted direction
- PredTag  out  QPW  queue slot assigned to this prediction
- ResolveValid  in  1  oldest in-flight branch resolved
- ResolveTaken  in  1  actual direction
- UpAddr  out  COUNTERPW  table update index
- UpdateAble  out  1  table update enable
- RightOrFault  out  1  1 = increment, 0 = decrement
- Attenuation  out  1  table halving pulse
- Mispredict  out  1  resolved direction differs from the prediction

## Operation
- **Index:** ReadAddr = FetchPc[COUNTERPW+1:2] ^ GhrEff. GhrEff = {Ghr[COUNTERPW-2:0], PredTaken} when PredValid is high in the same cycle (bypass), otherwise Ghr.
- **Lookup:** ReadAble = FetchValid & FetchReady, combinational. A 1-bit in-flight flag records the accepted lookup.
- **Prediction:** the cycle after an accepted, unsquashed lookup:
  - PredValid=1 and PredTaken=DoutCounter[1].
  - PredTag = tail pointer.
  - The queue entry {index, GhrEff used for the lookup, PredTaken} is written at the tail; the tail advances.
  - Ghr <= {GhrEff[COUNTERPW-2:0], PredTaken}.
- **FetchReady** = (count + inflight) < QDEPTH, and no mispredict this cycle.
- **Resolve:** while ResolveValid is high and the queue is non-empty (all combinational):
  - UpdateAble=1, UpAddr = head.index, RightOrFault = ResolveTaken.
  - Mispredict = ResolveTaken != head.pred.
  - The head pops.
- ResolveValid with an empty queue is ignored: no update, no Mispredict.
- **Mispredict recovery:**
  - Ghr <= {head.ghr[COUNTERPW-2:0], ResolveTaken}.
  - The whole queue is flushed: head = tail, count = 0.
  - The in-flight lookup is squashed: no PredValid next cycle, no entry written.
- **Simultaneous prediction and non-mispredicting resolve:** push and pop both occur; count is unchanged. Resolve takes priority over a same-cycle prediction for Ghr only when it mispredicts.
- **Attenuation:**
  - A resolve counter increments on each accepted resolve. On reaching ATTPERIOD-1 it wraps to 0 and sets a pending flag.
  - Attenuation=1 in the first cycle where pending=1 and UpdateAble=0; pending then clears.
  - Attenuation is never asserted together with UpdateAble.
- **Queue pointers:** wrap modulo QDEPTH. count ranges 0..QDEPTH.

## Timing
- **Reset (asynchronous, Rest=0):**
  - Ghr=0, head=tail=0, count=0, inflight=0, resolve counter=0, pending=0.
  - PredValid=0, PredTaken=0, PredTag=0, Attenuation=0.
  - Combinational outputs also read 0 under reset: ReadAble, UpdateAble, Mispredict, RightOrFault, UpAddr.
- Reset mid-operation discards all in-flight state. No PredValid follows a lookup accepted in the cycle before reset.
- **Lookup latency:** accept in cycle T gives PredValid in T+1. A new lookup may be accepted every cycle.
- **Update:** same cycle as ResolveValid. The table write lands at the next edge.
- **Mispredict:** a lookup in cycle T+1 already uses the repaired Ghr.

## Test plan
- **Reset state:** release Rest, FetchValid=0 -> all outputs 0, FetchReady=1.
- **Single lookup:** FetchPc=0x40, Ghr=0, DoutCounter=2'b10 -> ReadAddr=0x10; next cycle PredValid=1, PredTaken=1, PredTag=0, Ghr=6'b000001.
- **Back-to-back bypass:** lookups at 0x40 then 0x44, first DoutCounter=3 -> second ReadAddr = 0x11 ^ 6'b000001 = 0x10.
- **Queue full:** 8 lookups, no resolves -> FetchReady=0 once count+inflight=8. One correct resolve -> FetchReady=1, UpAddr equals the first index, RightOrFault=ResolveTaken.
- **Mispredict:** 3 predicted taken, resolve oldest not-taken -> Mispredict=1, UpdateAble=1, RightOrFault=0. Ghr becomes {saved Ghr<<1, 0}, count=0, and the in-flight lookup produces no PredValid.
- **Attenuation:** ATTPERIOD=4 with four consecutive resolves -> Attenuation pulses once, in the first cycle after the 4th resolve with UpdateAble=0, never overlapping UpdateAble.
